writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have one parameter: MEM_TIMEOUT, default 15, meaning the maximum number of cycles to wait for load data (range 1..255).
REQ-002 The block SHALL have this port: clk  input  1  the single clock; all state is updated on the rising edge.
REQ-003 The block SHALL have this port: rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have this port: in_valid  input  1  a retiring instruction is presented.
REQ-005 The block SHALL have this port: in_ready  output  1  the block can accept an instruction this cycle.
REQ-006 The block SHALL have this port: in_rd  input  5  destination register number.
REQ-007 The block SHALL have this port: in_alu  input  32  ALU result.
REQ-008 The block SHALL have this port: in_regwrite  input  1  the instruction writes a register.
REQ-009 The block SHALL have this port: in_memtoreg  input  1  the result comes from memory (load), not the ALU.
REQ-010 The block SHALL have this port: mem_rdata  input  32  load data.
REQ-011 The block SHALL have this port: mem_rvalid  input  1  mem_rdata is valid this cycle.
REQ-012 The block SHALL have this port: writeRegister  output  5  register-file write address.
REQ-013 The block SHALL have this port: writeBack  output  32  register-file write data.
REQ-014 The block SHALL have this port: RegisterWrite  output  1  register-file write strobe.
REQ-015 The block SHALL have this port: mem_err  output  1  one-cycle pulse on load timeout.
REQ-016 The block SHALL have this port: fwd_valid  output  1  the forwarding entry is valid.
REQ-017 The block SHALL have this port: fwd_reg  output  5  register number being forwarded.
REQ-018 The block SHALL have this port: fwd_data  output  32  value being forwarded.

Function
REQ-019 The FSM SHALL have three states: IDLE, WAIT_MEM and WRITE.
REQ-020 in_ready SHALL be 1 exactly in IDLE and WRITE, and 0 in WAIT_MEM.
REQ-021 An instruction SHALL be accepted on any cycle where in_valid and in_ready are both 1; on acceptance the block latches in_rd, in_alu, in_regwrite and in_memtoreg.
REQ-022 When an instruction is accepted with in_memtoreg=0, the next state SHALL be WRITE, with the write data taken from in_alu.
REQ-023 When an instruction is accepted with in_memtoreg=1, the next state SHALL be WAIT_MEM and the timeout counter SHALL be cleared to 0.
REQ-024 In WAIT_MEM, when mem_rvalid=1, the block SHALL latch mem_rdata as the write data and move to WRITE.
REQ-025 In WAIT_MEM, when mem_rvalid=0, the counter SHALL increment; when the counter reaches MEM_TIMEOUT-1 without mem_rvalid, the block SHALL move to IDLE and pulse mem_err for one cycle, with no register write.
REQ-026 mem_rvalid outside WAIT_MEM SHALL be ignored.
REQ-027 In WRITE, RegisterWrite SHALL be 1 for exactly that one cycle only when the latched regwrite=1 and the latched rd is non-zero.
REQ-028 Writes to register 0 SHALL always be suppressed.
REQ-029 In WRITE, writeRegister and writeBack SHALL show the latched rd and the selected data.
REQ-030 When not in WRITE, RegisterWrite SHALL be 0, and writeRegister and writeBack SHALL hold their last values.
REQ-031 Exit from WRITE SHALL go to WAIT_MEM or WRITE if an instruction is accepted in the same cycle (back-to-back), otherwise to IDLE.
REQ-032 Throughput SHALL be one ALU instruction per cycle.
REQ-033 Latency from acceptance to RegisterWrite SHALL be 1 cycle for ALU instructions, and 1 cycle after mem_rvalid for loads.
REQ-034 Data width SHALL be 32 bits with no transformation of the data.

Reset
REQ-035 While rst=0, asynchronously: the state SHALL be IDLE; RegisterWrite, mem_err and fwd_valid SHALL be 0; writeRegister, writeBack, fwd_reg, fwd_data and the counter SHALL be 0.
REQ-036 in_ready SHALL be 1 after reset is released.
REQ-037 A reset asserted in WAIT_MEM or WRITE SHALL abandon the instruction with no write.

Configuration
REQ-038 With the macro WRITEBACK_FWD_EN defined, fwd_valid, fwd_reg and fwd_data SHALL mirror RegisterWrite, writeRegister and writeBack in the same cycle, and additionally hold the most recent written entry (fwd_valid=1) until the next write or until reset.
REQ-039 With WRITEBACK_FWD_EN undefined, the fwd_* ports SHALL remain present but tied to 0, and no hold register SHALL exist.

Verification
REQ-040 Scenario: accept {rd=5, alu=0x0000_00AA, regwrite=1, memtoreg=0} -> on the next cycle RegisterWrite=1, writeRegister=5, writeBack=0xAA.
REQ-041 Scenario: a load to rd=7 with mem_rvalid arriving 3 cycles later carrying 0xDEAD_BEEF -> in_ready=0 for 3 cycles, then one write of 0xDEADBEEF to register 7.
REQ-042 Scenario: a load with no mem_rvalid and MEM_TIMEOUT=4 -> mem_err pulses after 4 cycles, no RegisterWrite, in_ready returns to 1.
REQ-043 Scenario: rd=0 with regwrite=1 and alu=0x1234 -> RegisterWrite stays 0.
REQ-044 Scenario: three back-to-back ALU instructions to rd=1, 2, 3 -> three consecutive RegisterWrite cycles, and in_ready stays 1.
REQ-045 Scenario: rst driven to 0 mid-WAIT_MEM, followed by mem_rvalid=1 -> no write occurs; with WRITEBACK_FWD_EN, fwd_valid=0 after reset.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results directly and waits (with timeout) for load data.
// Optional forwarding hold register enabled by the WRITEBACK_FWD_EN macro.
module writeback_unit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu,
    input  logic        in_regwrite,
    input  logic        in_memtoreg,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeBack,
    output logic        RegisterWrite,
    output logic        mem_err,
    output logic        fwd_valid,
    output logic [4:0]  fwd_reg,
    output logic [31:0] fwd_data
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    // Register 0 is hardwired to zero, so a write to it never reaches the file.
    function automatic logic write_enable(input logic regwrite, input logic [4:0] rd);
        return regwrite && (rd != 5'd0);
    endfunction

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [4:0]  rd_r;
    logic        regwrite_r;
    logic        in_ready_r;
    logic        reg_write_r;
    logic [4:0]  write_register_r;
    logic [31:0] write_back_r;
    logic        mem_err_r;

    logic        accept_s;
    logic        alu_done_s;
    logic        load_done_s;
    logic        wr_fire_s;
    logic [4:0]  wr_reg_s;
    logic [31:0] wr_data_s;

    // Acceptance is impossible in WAIT_MEM, so an ALU retire and a load completion never coincide.
    assign accept_s    = in_valid && in_ready_r;
    assign alu_done_s  = accept_s && !in_memtoreg;
    assign load_done_s = (state_r == WAIT_MEM) && mem_rvalid;
    assign wr_fire_s   = (alu_done_s && write_enable(in_regwrite, in_rd)) ||
                         (load_done_s && write_enable(regwrite_r, rd_r));
    assign wr_reg_s    = load_done_s ? rd_r : in_rd;
    assign wr_data_s   = load_done_s ? mem_rdata : in_alu;

    // Main FSM with registered handshake, write-port and error outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= IDLE;
            cnt_r            <= 8'd0;
            rd_r             <= 5'd0;
            regwrite_r       <= 1'b0;
            in_ready_r       <= 1'b1;
            reg_write_r      <= 1'b0;
            write_register_r <= 5'd0;
            write_back_r     <= 32'd0;
            mem_err_r        <= 1'b0;
        end else begin
            mem_err_r   <= 1'b0;
            reg_write_r <= wr_fire_s;
            case (state_r)
                IDLE, WRITE: begin
                    if (accept_s) begin
                        rd_r       <= in_rd;
                        regwrite_r <= in_regwrite;
                        if (in_memtoreg) begin
                            state_r    <= WAIT_MEM;
                            in_ready_r <= 1'b0;
                            cnt_r      <= 8'd0;
                        end else begin
                            state_r          <= WRITE;
                            in_ready_r       <= 1'b1;
                            write_register_r <= wr_reg_s;
                            write_back_r     <= wr_data_s;
                        end
                    end else begin
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        state_r          <= WRITE;
                        in_ready_r       <= 1'b1;
                        write_register_r <= wr_reg_s;
                        write_back_r     <= wr_data_s;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                        mem_err_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_r;
    assign RegisterWrite = reg_write_r;
    assign writeRegister = write_register_r;
    assign writeBack     = write_back_r;
    assign mem_err       = mem_err_r;

`ifdef WRITEBACK_FWD_EN
    logic        fwd_valid_r;
    logic [4:0]  fwd_reg_r;
    logic [31:0] fwd_data_r;

    // Forwarding entry: loaded together with each real write, held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_valid_r <= 1'b0;
            fwd_reg_r   <= 5'd0;
            fwd_data_r  <= 32'd0;
        end else if (wr_fire_s) begin
            fwd_valid_r <= 1'b1;
            fwd_reg_r   <= wr_reg_s;
            fwd_data_r  <= wr_data_s;
        end else begin
            fwd_valid_r <= fwd_valid_r;
            fwd_reg_r   <= fwd_reg_r;
            fwd_data_r  <= fwd_data_r;
        end
    end

    assign fwd_valid = fwd_valid_r;
    assign fwd_reg   = fwd_reg_r;
    assign fwd_data  = fwd_data_r;
`else
    assign fwd_valid = 1'b0;
    assign fwd_reg   = 5'd0;
    assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (MEM_TIMEOUT = 4).
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_alu;
    logic        in_regwrite;
    logic        in_memtoreg;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [4:0]  writeRegister;
    logic [31:0] writeBack;
    logic        RegisterWrite;
    logic        mem_err;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    writeback_unit #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_alu(in_alu), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .writeRegister(writeRegister), .writeBack(writeBack), .RegisterWrite(RegisterWrite),
        .mem_err(mem_err),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
        check_eq({tag, ".we"}, {31'd0, RegisterWrite}, {31'd0, we});
        check_eq({tag, ".rd"}, {27'd0, writeRegister}, {27'd0, rd});
        check_eq({tag, ".data"}, writeBack, data);
    endtask

    task automatic check_fwd(input string tag, input logic v, input logic [4:0] rd, input logic [31:0] data);
`ifdef WRITEBACK_FWD_EN
        check_eq({tag, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, v});
        check_eq({tag, ".fwd_reg"}, {27'd0, fwd_reg}, {27'd0, rd});
        check_eq({tag, ".fwd_data"}, fwd_data, data);
`else
        check_eq({tag, ".fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
        check_eq({tag, ".fwd_reg"}, {27'd0, fwd_reg}, 32'd0);
        check_eq({tag, ".fwd_data"}, fwd_data, 32'd0);
`endif
    endtask

    task automatic drive_instr(input logic [4:0] rd, input logic [31:0] alu, input logic rw, input logic m2r);
        in_valid    = 1'b1;
        in_rd       = rd;
        in_alu      = alu;
        in_regwrite = rw;
        in_memtoreg = m2r;
    endtask

    task automatic drive_idle();
        in_valid    = 1'b0;
        in_rd       = 5'd0;
        in_alu      = 32'd0;
        in_regwrite = 1'b0;
        in_memtoreg = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        mem_rdata  = 32'd0;
        mem_rvalid = 1'b0;
        drive_idle();

        // Reset state
        repeat (2) @(negedge clk);
        check_wr("reset", 1'b0, 5'd0, 32'd0);
        check_eq("reset.mem_err", {31'd0, mem_err}, 32'd0);
        check_fwd("reset", 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_reset.in_ready", {31'd0, in_ready}, 32'd1);

        // Single ALU write to r5, then hold
        drive_instr(5'd5, 32'h0000_00AA, 1'b1, 1'b0);
        @(negedge clk);
        check_wr("alu_r5", 1'b1, 5'd5, 32'h0000_00AA);
        check_eq("alu_r5.in_ready", {31'd0, in_ready}, 32'd1);
        check_fwd("alu_r5", 1'b1, 5'd5, 32'h0000_00AA);
        drive_idle();
        @(negedge clk);
        check_wr("alu_r5_hold", 1'b0, 5'd5, 32'h0000_00AA);
        check_fwd("alu_r5_hold", 1'b1, 5'd5, 32'h0000_00AA);

        // Write to r0 suppressed
        drive_instr(5'd0, 32'h0000_1234, 1'b1, 1'b0);
        @(negedge clk);
        check_wr("rd0", 1'b0, 5'd0, 32'h0000_1234);
        check_fwd("rd0", 1'b1, 5'd5, 32'h0000_00AA);
        drive_idle();
        @(negedge clk);

        // Three back-to-back ALU writes
        drive_instr(5'd1, 32'h0000_0011, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_wr($sformatf("b2b%0d", i), 1'b1, 5'(i + 1), 32'h11 * (i + 1));
            check_eq($sformatf("b2b%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
            check_fwd($sformatf("b2b%0d", i), 1'b1, 5'(i + 1), 32'h11 * (i + 1));
            if (i < 2) drive_instr(5'(i + 2), 32'h11 * (i + 2), 1'b1, 1'b0);
            else drive_instr(5'd9, 32'h0000_0055, 1'b0, 1'b0);
        end

        // regwrite=0: no strobe, port still shows the instruction
        @(negedge clk);
        check_wr("norw", 1'b0, 5'd9, 32'h0000_0055);
        check_fwd("norw", 1'b1, 5'd3, 32'h0000_0033);
        drive_idle();

        // mem_rvalid in IDLE is ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0BAD;
        @(negedge clk);
        @(negedge clk);
        check_wr("rvalid_idle", 1'b0, 5'd9, 32'h0000_0055);
        check_eq("rvalid_idle.in_ready", {31'd0, in_ready}, 32'd1);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;

        // Load to r7, data after 3 wait cycles; competing instruction must stall
        drive_instr(5'd7, 32'h0000_FFFF, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("load_wait%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
            check_eq($sformatf("load_wait%0d.we", k), {31'd0, RegisterWrite}, 32'd0);
            drive_instr(5'd20, 32'h0000_2020, 1'b1, 1'b0);
            if (k == 3) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
            end
        end
        @(negedge clk);
        drive_idle();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        check_wr("load_r7", 1'b1, 5'd7, 32'hDEAD_BEEF);
        check_eq("load_r7.in_ready", {31'd0, in_ready}, 32'd1);
        check_fwd("load_r7", 1'b1, 5'd7, 32'hDEAD_BEEF);
        @(negedge clk);
        check_wr("load_r7_after", 1'b0, 5'd7, 32'hDEAD_BEEF);

        // Load timeout after 4 cycles
        drive_instr(5'd8, 32'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drive_idle();
            check_eq($sformatf("tmo_wait%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
            check_eq($sformatf("tmo_wait%0d.mem_err", k), {31'd0, mem_err}, 32'd0);
        end
        @(negedge clk);
        check_eq("tmo.mem_err", {31'd0, mem_err}, 32'd1);
        check_eq("tmo.in_ready", {31'd0, in_ready}, 32'd1);
        check_wr("tmo", 1'b0, 5'd7, 32'hDEAD_BEEF);
        check_fwd("tmo", 1'b1, 5'd7, 32'hDEAD_BEEF);
        @(negedge clk);
        check_eq("tmo_after.mem_err", {31'd0, mem_err}, 32'd0);
        check_wr("tmo_after", 1'b0, 5'd7, 32'hDEAD_BEEF);

        // Reset during WAIT_MEM abandons the load
        drive_instr(5'd10, 32'd0, 1'b1, 1'b1);
        @(negedge clk);
        drive_idle();
        check_eq("rst_mid.in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check_wr("rst_mid", 1'b0, 5'd0, 32'd0);
        check_fwd("rst_mid", 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        @(negedge clk);
        check_wr("rst_after", 1'b0, 5'd0, 32'd0);
        check_eq("rst_after.in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_after.mem_err", {31'd0, mem_err}, 32'd0);
        check_fwd("rst_after", 1'b0, 5'd0, 32'd0);

        // Recovery write to r31
        drive_instr(5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge clk);
        drive_idle();
        check_wr("r31", 1'b1, 5'd31, 32'hFFFF_FFFF);
        check_fwd("r31", 1'b1, 5'd31, 32'hFFFF_FFFF);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
